// File: rtl/hazard_controller.sv
// hazard_controller
//   Hazard controller for the three-stage ID -> EX -> MEM/WB MIPS datapath.
//   It tracks the destination registers of the instructions in EX and MEM and
//   drives the single forwarding port of the decode-stage operand selector.
//   It stalls on load-use hazards, on two-source dependencies that one port
//   cannot serve, and while the mul/div unit is busy. It also counts stall
//   cycles for performance measurement.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   id_valid          ID stage holds a valid instruction
//   id_instr          ID instruction word (rs = [25:21], rt = [20:16])
//   id_uses_rs/rt     instruction reads rs / rt
//   id_wr_en/wr_addr  instruction writes GPR id_wr_addr
//   id_is_load        result is available only after MEM
//   id_is_muldiv      instruction starts the mul/div unit
//   id_reads_hilo     instruction reads HI/LO
//   flush             kill the ID instruction (branch redirect)
//   stall             hold PC and IF/ID, insert a bubble into EX
//   fwd_ra            register to forward (0 = none)
//   fwd_src           0 = EX-stage ALU result, 1 = MEM/WB result
//   muldiv_busy       mul/div unit still computing
//   stall_count       stall cycles since reset (wraps)
module hazard_controller #(
    parameter int unsigned MULDIV_LATENCY = 32,
    parameter int unsigned STALL_CNT_W    = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   id_valid,
    input  logic [31:0]            id_instr,
    input  logic                   id_uses_rs,
    input  logic                   id_uses_rt,
    input  logic                   id_wr_en,
    input  logic [4:0]             id_wr_addr,
    input  logic                   id_is_load,
    input  logic                   id_is_muldiv,
    input  logic                   id_reads_hilo,
    input  logic                   flush,
    output logic                   stall,
    output logic [4:0]             fwd_ra,
    output logic                   fwd_src,
    output logic                   muldiv_busy,
    output logic [STALL_CNT_W-1:0] stall_count
);

    localparam logic [5:0] MD_LOAD = 6'(MULDIV_LATENCY - 1);

    logic [4:0] rs, rt;
    logic       instr_unused;

    logic       ex_v, ex_wr, ex_ld;
    logic [4:0] ex_addr;
    logic       mem_v, mem_wr;
    logic [4:0] mem_addr;
    logic [5:0] md_cnt;
    logic [STALL_CNT_W-1:0] cnt_q;

    logic need_rs, need_rt;
    logic mex_rs, mex_rt, mmem_rs, mmem_rt;
    logic hit_rs, hit_rt;
    logic load_use, md_stall, dual;
    logic advance;

    assign rs           = id_instr[25:21];
    assign rt           = id_instr[20:16];
    assign instr_unused = ^{id_instr[31:26], id_instr[15:0]};

    function automatic logic tracks(input logic v, input logic wr,
                                    input logic [4:0] a, input logic [4:0] r);
        return v & wr & (a != 5'd0) & (a == r);
    endfunction

    always_comb begin
        // rs == rt is one source; it is attributed to rs when rs is read
        need_rs  = id_uses_rs;
        need_rt  = id_uses_rt & ~(id_uses_rs & (rs == rt));

        mex_rs   = tracks(ex_v, ex_wr, ex_addr, rs);
        mex_rt   = tracks(ex_v, ex_wr, ex_addr, rt);
        mmem_rs  = tracks(mem_v, mem_wr, mem_addr, rs);
        mmem_rt  = tracks(mem_v, mem_wr, mem_addr, rt);

        hit_rs   = need_rs & (mex_rs | mmem_rs);
        hit_rt   = need_rt & (mex_rt | mmem_rt);

        muldiv_busy = (md_cnt != 6'd0);
        load_use = id_valid & ex_ld & ((need_rs & mex_rs) | (need_rt & mex_rt));
        md_stall = id_valid & (id_is_muldiv | id_reads_hilo) & muldiv_busy;
        dual     = id_valid & hit_rs & hit_rt;
        stall    = load_use | md_stall | dual;
        advance  = id_valid & ~stall & ~flush;
    end

    // EX wins over MEM when both match: it holds the younger write
    always_comb begin
        fwd_ra  = '0;
        fwd_src = 1'b0;
        if (!stall) begin
            if (hit_rs && !hit_rt) begin
                fwd_ra  = rs;
                fwd_src = ~(mex_rs & ~ex_ld);
            end else if (hit_rt && !hit_rs) begin
                fwd_ra  = rt;
                fwd_src = ~(mex_rt & ~ex_ld);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_v     <= 1'b0;
            ex_wr    <= 1'b0;
            ex_ld    <= 1'b0;
            ex_addr  <= '0;
            mem_v    <= 1'b0;
            mem_wr   <= 1'b0;
            mem_addr <= '0;
        end else begin
            mem_v    <= ex_v;
            mem_wr   <= ex_wr;
            mem_addr <= ex_addr;
            if (advance) begin
                ex_v    <= 1'b1;
                ex_wr   <= id_wr_en;
                ex_ld   <= id_is_load;
                ex_addr <= id_wr_addr;
            end else begin
                ex_v    <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt <= '0;
        end else if (advance && id_is_muldiv) begin
            md_cnt <= MD_LOAD;
        end else if (md_cnt != 6'd0) begin
            md_cnt <= md_cnt - 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (stall) begin
            cnt_q <= cnt_q + STALL_CNT_W'(1);
        end
    end

    assign stall_count = cnt_q;

endmodule

// File: tb/tb_hazard_controller.sv
// tb_hazard_controller
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against an in-flight instruction model (youngest writer lookup, mul/div
//   age since issue, modulo stall counter).
module tb_hazard_controller;

    localparam int unsigned LAT = 4;
    localparam int unsigned CW  = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          id_valid;
    logic [31:0]   id_instr;
    logic          id_uses_rs, id_uses_rt, id_wr_en;
    logic [4:0]    id_wr_addr;
    logic          id_is_load, id_is_muldiv, id_reads_hilo, flush;
    logic          stall;
    logic [4:0]    fwd_ra;
    logic          fwd_src;
    logic          muldiv_busy;
    logic [CW-1:0] stall_count;

    hazard_controller #(.MULDIV_LATENCY(LAT), .STALL_CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_instr(id_instr),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_wr_en(id_wr_en),
        .id_wr_addr(id_wr_addr), .id_is_load(id_is_load),
        .id_is_muldiv(id_is_muldiv), .id_reads_hilo(id_reads_hilo),
        .flush(flush), .stall(stall), .fwd_ra(fwd_ra), .fwd_src(fwd_src),
        .muldiv_busy(muldiv_busy), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       v;
        logic       wr;
        logic [4:0] a;
        logic       ld;
    } slot_t;

    slot_t         pipe [2];   // [0] = EX, [1] = MEM
    int            md_age;     // clock edges since a mul/div entered EX
    logic [CW-1:0] m_cnt;
    logic          e_stall, e_src, e_busy;
    logic [4:0]    e_ra;

    task automatic model_reset();
        pipe[0] = '0;
        pipe[1] = '0;
        md_age  = 1000;
        m_cnt   = '0;
    endtask

    // 0 = no producer, 1 = EX, 2 = MEM (youngest first)
    function automatic int producer(input logic [4:0] r);
        for (int i = 0; i < 2; i++)
            if (pipe[i].v && pipe[i].wr && pipe[i].a == r && r != 5'd0)
                return i + 1;
        return 0;
    endfunction

    task automatic model_eval();
        logic [4:0] srcs[$];
        logic [4:0] rs, rt, hit;
        int         nmatch;
        logic       lu;
        rs = id_instr[25:21];
        rt = id_instr[20:16];
        nmatch = 0;
        lu = 1'b0;
        hit = '0;
        if (id_uses_rs) srcs.push_back(rs);
        if (id_uses_rt && !(id_uses_rs && rt == rs)) srcs.push_back(rt);
        foreach (srcs[i]) begin
            int p;
            p = producer(srcs[i]);
            if (p != 0) begin
                nmatch++;
                hit = srcs[i];
                if (p == 1 && pipe[0].ld) lu = 1'b1;
            end
        end
        e_busy  = (md_age < int'(LAT) - 1);
        e_stall = id_valid && (lu || ((id_is_muldiv || id_reads_hilo) && e_busy) || nmatch == 2);
        if (!e_stall && nmatch == 1) begin
            e_ra  = hit;
            e_src = (producer(hit) == 1 && !pipe[0].ld) ? 1'b0 : 1'b1;
        end else begin
            e_ra  = '0;
            e_src = 1'b0;
        end
    endtask

    // ---------------- stimulus ----------------
    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                         input logic urs, input logic urt, input logic wr,
                         input logic [4:0] wa, input logic ld, input logic md,
                         input logic hilo, input logic fl);
        id_valid      = v;
        id_instr      = {6'($urandom), rs, rt, 16'($urandom)};
        id_uses_rs    = urs;
        id_uses_rt    = urt;
        id_wr_en      = wr;
        id_wr_addr    = wa;
        id_is_load    = ld;
        id_is_muldiv  = md;
        id_reads_hilo = hilo;
        flush         = fl;
        @(negedge clk);
        model_eval();
        chk("stall",       32'(stall),       32'(e_stall));
        chk("fwd_ra",      32'(fwd_ra),      32'(e_ra));
        chk("fwd_src",     32'(fwd_src),     32'(e_src));
        chk("muldiv_busy", 32'(muldiv_busy), 32'(e_busy));
        chk("stall_count", 32'(stall_count), 32'(m_cnt));
    endtask

    task automatic tick();
        logic adv;
        @(posedge clk);
        adv = id_valid && !e_stall && !flush;
        pipe[1] = pipe[0];
        pipe[0] = adv ? slot_t'{v: 1'b1, wr: id_wr_en, a: id_wr_addr, ld: id_is_load} : '0;
        if (adv && id_is_muldiv) md_age = 0;
        else if (md_age < 1000)  md_age++;
        if (e_stall) m_cnt++;
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        id_valid = 1'b0; id_instr = '0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
        id_wr_en = 1'b0; id_wr_addr = '0; id_is_load = 1'b0;
        id_is_muldiv = 1'b0; id_reads_hilo = 1'b0; flush = 1'b0;
        #1;
        model_reset();
        chk("rst_stall", 32'(stall),       32'd0);
        chk("rst_fwdra", 32'(fwd_ra),      32'd0);
        chk("rst_src",   32'(fwd_src),     32'd0);
        chk("rst_busy",  32'(muldiv_busy), 32'd0);
        chk("rst_cnt",   32'(stall_count), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // ALU result forwarded from EX, then from MEM
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd3, 0, 0, 0, 0);            // addi $3
        tick();
        drive(1, 5'd3, 5'd5, 1, 1, 1, 5'd4, 0, 0, 0, 0);            // add $4,$3,$5
        chk("s1_stall", 32'(stall), 32'd0);
        chk("s1_ra",    32'(fwd_ra), 32'd3);
        chk("s1_src",   32'(fwd_src), 32'd0);
        tick();
        drive(1, 5'd3, 5'd0, 1, 0, 0, 5'd0, 0, 0, 0, 0);
        chk("s1_mem_ra",  32'(fwd_ra), 32'd3);
        chk("s1_mem_src", 32'(fwd_src), 32'd1);
        tick();

        // load-use: one stall cycle, then forward from MEM
        do_reset();
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd2, 1, 0, 0, 0);            // lw $2
        tick();
        drive(1, 5'd2, 5'd9, 1, 1, 1, 5'd10, 0, 0, 0, 0);
        chk("s2_stall", 32'(stall), 32'd1);
        tick();
        drive(1, 5'd2, 5'd9, 1, 1, 1, 5'd10, 0, 0, 0, 0);
        chk("s2_stall_after", 32'(stall), 32'd0);
        chk("s2_ra",  32'(fwd_ra), 32'd2);
        chk("s2_src", 32'(fwd_src), 32'd1);
        chk("s2_cnt", 32'(stall_count), 32'd1);
        tick();

        // $0 is never forwarded
        do_reset();
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd0, 0, 0, 0, 0);
        tick();
        drive(1, 5'd0, 5'd0, 1, 1, 1, 5'd1, 0, 0, 0, 0);
        chk("s3_stall", 32'(stall), 32'd0);
        chk("s3_ra",    32'(fwd_ra), 32'd0);
        tick();

        // dual dependency: EX $6, MEM $7
        do_reset();
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd7, 0, 0, 0, 0);
        tick();
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd6, 0, 0, 0, 0);
        tick();
        drive(1, 5'd6, 5'd7, 1, 1, 1, 5'd8, 0, 0, 0, 0);
        chk("s4_stall", 32'(stall), 32'd1);
        tick();
        drive(1, 5'd6, 5'd7, 1, 1, 1, 5'd8, 0, 0, 0, 0);
        chk("s4_stall_after", 32'(stall), 32'd0);
        chk("s4_ra",  32'(fwd_ra), 32'd6);
        chk("s4_src", 32'(fwd_src), 32'd1);
        tick();

        // mul/div busy: div then mflo stalls LAT-1 cycles
        do_reset();
        drive(1, 5'd4, 5'd5, 1, 1, 0, 5'd0, 0, 1, 0, 0);            // div
        tick();
        for (int i = 0; i < int'(LAT) - 1; i++) begin
            drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd12, 0, 0, 1, 0);       // mflo $12
            chk("s5_stall", 32'(stall), 32'd1);
            chk("s5_busy",  32'(muldiv_busy), 32'd1);
            tick();
        end
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd12, 0, 0, 1, 0);
        chk("s5_stall_end", 32'(stall), 32'd0);
        chk("s5_busy_end",  32'(muldiv_busy), 32'd0);
        tick();

        // async reset mid-stall with a load in EX and mul/div running
        do_reset();
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd1, 1, 0, 0, 0);            // lw $1
        tick();
        drive(1, 5'd1, 5'd0, 1, 0, 1, 5'd2, 0, 0, 0, 0);            // stall once
        tick();
        drive(1, 5'd1, 5'd0, 1, 0, 1, 5'd2, 0, 0, 0, 0);
        tick();
        drive(1, 5'd0, 5'd0, 0, 0, 0, 5'd0, 0, 1, 0, 0);            // div
        tick();
        drive(1, 5'd0, 5'd0, 0, 0, 1, 5'd9, 1, 0, 0, 0);            // lw $9
        tick();
        drive(1, 5'd9, 5'd0, 1, 0, 1, 5'd3, 0, 0, 1, 0);            // mfhi-like, reads $9
        chk("s6_stall_pre", 32'(stall), 32'd1);
        chk("s6_busy_pre",  32'(muldiv_busy), 32'd1);
        chk("s6_cnt_pre",   32'(stall_count), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s6_stall", 32'(stall),       32'd0);
        chk("s6_ra",    32'(fwd_ra),      32'd0);
        chk("s6_busy",  32'(muldiv_busy), 32'd0);
        chk("s6_cnt",   32'(stall_count), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1, 5'd9, 5'd0, 1, 0, 1, 5'd3, 0, 0, 1, 0);
        chk("s6_after_ra", 32'(fwd_ra), 32'd0);
        tick();

        // randomized traffic on a small register set to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                drive($urandom_range(0, 99) < 85,
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      1'($urandom), 1'($urandom), $urandom_range(0, 99) < 80,
                      5'($urandom_range(0, 3)), $urandom_range(0, 99) < 25,
                      $urandom_range(0, 99) < 10, $urandom_range(0, 99) < 10,
                      $urandom_range(0, 99) < 10);
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
